// File: rtl/voice_alloc_if.sv
// voice_alloc_if: key bitmap, scan handshake and voice outputs of the voice allocator
interface voice_alloc_if #(
    parameter int NUM_KEYS   = 88,
    parameter int NUM_VOICES = 8,
    parameter int NOTE_W     = 7
);
    logic [NUM_KEYS-1:0]          keys_in;
    logic                         scan_start;
    logic                         busy;
    logic                         scan_done;
    logic [NUM_VOICES*NOTE_W-1:0] voice_note;
    logic [NUM_VOICES-1:0]        voice_gate;
    logic [NUM_VOICES-1:0]        voice_trig;
    logic [7:0]                   drop_cnt;
    modport master (
        output keys_in, scan_start,
        input  busy, scan_done, voice_note, voice_gate, voice_trig, drop_cnt
    );
    modport slave (
        input  keys_in, scan_start,
        output busy, scan_done, voice_note, voice_gate, voice_trig, drop_cnt
    );
endinterface

// File: rtl/voice_alloc.sv
// voice_alloc: scans a snapshot of held keys one per cycle, mapping note-ons/offs onto voice slots
module voice_alloc #(
    parameter int NUM_KEYS   = 88,
    parameter int NUM_VOICES = 8,
    parameter int NOTE_W     = 7
) (
    input logic          clk,
    input logic          reset,
    voice_alloc_if.slave bus
);
    localparam int IDX_W = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1;
    typedef enum logic [1:0] {IDLE, SNAP, SCAN} state_t;
    state_t                       state_q, state_d;
    logic [NUM_KEYS-1:0]          key_snap_q, key_snap_d, assigned_q, assigned_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [NUM_VOICES*NOTE_W-1:0] note_q, note_d;
    logic [NUM_VOICES-1:0]        gate_q, gate_d, trig_q, trig_d, free_oh, hit_oh;
    logic                         done_q, done_d, last, key_on, key_asg, scanning;
    logic [7:0]                   drop_q, drop_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            key_snap_q <= '0;
            assigned_q <= '0;
            idx_q      <= '0;
            note_q     <= '0;
            gate_q     <= '0;
            trig_q     <= '0;
            done_q     <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            key_snap_q <= key_snap_d;
            assigned_q <= assigned_d;
            idx_q      <= idx_d;
            note_q     <= note_d;
            gate_q     <= gate_d;
            trig_q     <= trig_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    assign last     = idx_q == IDX_W'(NUM_KEYS - 1);
    assign scanning = state_q == SCAN;

    always_comb begin
        state_d = state_q == IDLE ? (bus.scan_start ? SNAP : IDLE)
                : state_q == SNAP ? SCAN
                : state_q == SCAN ? (last ? IDLE : SCAN)
                : IDLE;
    end

    assign key_on  = key_snap_q[idx_q];
    assign key_asg = assigned_q[idx_q];
    // lowest clear gate bit as a one-hot; zero when every voice is sounding
    assign free_oh = ~gate_q & (gate_q + NUM_VOICES'(1));

    always_comb begin
        hit_oh = '0;
        for (int v = 0; v < NUM_VOICES; v++)
            hit_oh[v] = gate_q[v] && note_q[v*NOTE_W +: NOTE_W] == NOTE_W'(idx_q);
    end

    always_comb begin
        key_snap_d = state_q == SNAP ? bus.keys_in : key_snap_q;
        idx_d      = state_q == SNAP ? '0 : scanning ? idx_q + IDX_W'(1) : idx_q;
        assigned_d = assigned_q;
        note_d     = note_q;
        gate_d     = gate_q;
        trig_d     = '0;
        drop_d     = drop_q;
        done_d     = scanning && last;
        if (scanning && key_on && !key_asg) begin
            if (|free_oh) begin
                assigned_d[idx_q] = 1'b1;
                gate_d            = gate_q | free_oh;
                trig_d            = free_oh;
                for (int v = 0; v < NUM_VOICES; v++)
                    if (free_oh[v]) note_d[v*NOTE_W +: NOTE_W] = NOTE_W'(idx_q);
            end else begin
                drop_d = drop_q + {7'd0, drop_q != 8'hFF};
            end
        end else if (scanning && !key_on && key_asg) begin
            // note stays in place so a release tail can still read it
            assigned_d[idx_q] = 1'b0;
            gate_d            = gate_q & ~hit_oh;
        end
    end

    always_comb begin
        bus.busy       = state_q != IDLE;
        bus.scan_done  = done_q;
        bus.voice_note = note_q;
        bus.voice_gate = gate_q;
        bus.voice_trig = trig_q;
        bus.drop_cnt   = drop_q;
    end
endmodule

// File: tb/tb_voice_alloc.sv
// tb_voice_alloc: directed and randomized scan passes checked against a key-by-key voice model
module tb_voice_alloc;
    localparam int NK = 88, NV = 8, NW = 7;
    logic clk = 1'b0;
    logic reset = 1'b1;
    voice_alloc_if #(.NUM_KEYS(NK), .NUM_VOICES(NV), .NOTE_W(NW)) bus ();
    voice_alloc #(.NUM_KEYS(NK), .NUM_VOICES(NV), .NOTE_W(NW)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    int checks = 0, passed = 0;
    logic m_asg [NK];
    logic m_gate [NV];
    int m_note [NV];
    int m_drop;
    logic [NV-1:0] exp_trig [256];
    int done_first, done_second, done_cnt, busy_cnt, busy_at_done, trig_bad, trig_tot;

    function automatic void model_clear();
        foreach (m_asg[k]) m_asg[k] = 1'b0;
        foreach (m_gate[v]) begin m_gate[v] = 1'b0; m_note[v] = 0; end
        m_drop = 0;
    endfunction

    // one pass of the allocation rules; base is the sample index of the pass start edge minus one
    function automatic void model_pass(input logic [NK-1:0] keys, input int base);
        for (int k = 0; k < NK; k++) begin
            if (keys[k] && !m_asg[k]) begin
                int f = -1;
                for (int v = NV - 1; v >= 0; v--) if (!m_gate[v]) f = v;
                if (f >= 0) begin
                    m_gate[f] = 1'b1; m_note[f] = k; m_asg[k] = 1'b1;
                    exp_trig[base + k + 3][f] = 1'b1;
                end else if (m_drop < 255) m_drop++;
            end else if (!keys[k] && m_asg[k]) begin
                for (int v = 0; v < NV; v++) if (m_gate[v] && m_note[v] == k) m_gate[v] = 1'b0;
                m_asg[k] = 1'b0;
            end
        end
    endfunction

    function automatic logic [NV-1:0] exp_gate();
        logic [NV-1:0] g;
        for (int v = 0; v < NV; v++) g[v] = m_gate[v];
        return g;
    endfunction

    function automatic logic [NV*NW-1:0] exp_note();
        logic [NV*NW-1:0] r;
        for (int v = 0; v < NV; v++) r[v*NW +: NW] = NW'(m_note[v]);
        return r;
    endfunction

    function automatic logic [NK-1:0] rand_keys(input int pct);
        logic [NK-1:0] k;
        for (int i = 0; i < NK; i++) k[i] = $urandom_range(99, 0) < pct;
        return k;
    endfunction

    function automatic int dup_notes();
        int d = 0;
        for (int i = 0; i < NV; i++)
            for (int j = i + 1; j < NV; j++)
                if (bus.voice_gate[i] && bus.voice_gate[j] && bus.voice_note[i*NW +: NW] == bus.voice_note[j*NW +: NW]) d++;
        return d;
    endfunction

    task automatic do_reset();
        reset = 1'b1; bus.scan_start = 1'b0; bus.keys_in = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
    endtask

    task automatic run_pass(input logic [NK-1:0] keys, input int len, input bit hold, input bit toggle, input int pa, input int pb);
        foreach (exp_trig[i]) exp_trig[i] = '0;
        model_pass(keys, 0);
        if (hold) model_pass(keys, 90);
        done_first = 0; done_second = 0; done_cnt = 0; busy_cnt = 0; busy_at_done = -1; trig_bad = 0; trig_tot = 0;
        bus.keys_in = keys; bus.scan_start = 1'b1;
        for (int n = 1; n <= len; n++) begin
            @(posedge clk); #1;
            if (bus.scan_done) begin
                done_cnt++;
                if (done_first == 0) begin done_first = n; busy_at_done = int'(bus.busy); end
                else done_second = n;
            end
            busy_cnt += int'(bus.busy);
            if (bus.voice_trig !== exp_trig[n]) trig_bad++;
            trig_tot += $countones(bus.voice_trig);
            if (toggle && n >= 2) bus.keys_in = rand_keys(50);
            bus.scan_start = hold ? n < 180 : (n + 1 == pa || n + 1 == pb);
        end
        bus.scan_start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0h expected 0", bus.busy); else passed++;
        checks++; if (bus.scan_done !== 1'b0) $display("FAIL reset_done: got %0h expected 0", bus.scan_done); else passed++;
        checks++; if (bus.voice_gate !== '0 || bus.voice_trig !== '0) $display("FAIL reset_gate_trig: got %0h/%0h expected 0/0", bus.voice_gate, bus.voice_trig); else passed++;
        checks++; if (bus.voice_note !== '0) $display("FAIL reset_note: got %0h expected 0", bus.voice_note); else passed++;
        checks++; if (bus.drop_cnt !== 8'd0) $display("FAIL reset_drop: got %0d expected 0", bus.drop_cnt); else passed++;
    endtask

    task automatic test_two_keys();
        logic [NK-1:0] keys = '0;
        do_reset();
        keys[3] = 1'b1; keys[40] = 1'b1;
        run_pass(keys, 95, 0, 0, 0, 0);
        checks++; if (done_first !== 90) $display("FAIL two_done_cycle: got %0d expected 90", done_first); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL two_done_count: got %0d expected 1", done_cnt); else passed++;
        checks++; if (busy_cnt !== 89 || busy_at_done !== 0) $display("FAIL two_busy: got %0d/%0d expected 89/0", busy_cnt, busy_at_done); else passed++;
        checks++; if (bus.voice_gate !== 8'h03) $display("FAIL two_gate: got %0h expected 03", bus.voice_gate); else passed++;
        checks++; if (bus.voice_note[13:0] !== {7'd40, 7'd3}) $display("FAIL two_note: got %0h expected %0h", bus.voice_note[13:0], {7'd40, 7'd3}); else passed++;
        checks++; if (trig_bad !== 0 || trig_tot !== 2) $display("FAIL two_trig: got bad=%0d tot=%0d expected 0/2", trig_bad, trig_tot); else passed++;
    endtask

    task automatic test_overflow();
        logic [NK-1:0] keys = '0;
        logic [NV*NW-1:0] want;
        do_reset();
        keys[9:0] = 10'h3FF;
        for (int v = 0; v < NV; v++) want[v*NW +: NW] = NW'(v);
        run_pass(keys, 95, 0, 0, 0, 0);
        checks++; if (bus.voice_gate !== 8'hFF) $display("FAIL ovf_gate: got %0h expected ff", bus.voice_gate); else passed++;
        checks++; if (bus.voice_note !== want) $display("FAIL ovf_note: got %0h expected %0h", bus.voice_note, want); else passed++;
        checks++; if (bus.drop_cnt !== 8'd2) $display("FAIL ovf_drop: got %0d expected 2", bus.drop_cnt); else passed++;
        keys[2] = 1'b0;
        want[2*NW +: NW] = 7'd8;
        run_pass(keys, 95, 0, 0, 0, 0);
        checks++; if (bus.voice_note !== want || bus.voice_gate !== 8'hFF) $display("FAIL ovf_reuse: got %0h/%0h expected %0h/ff", bus.voice_note, bus.voice_gate, want); else passed++;
        checks++; if (bus.drop_cnt !== 8'd3) $display("FAIL ovf_drop2: got %0d expected 3", bus.drop_cnt); else passed++;
        checks++; if (trig_bad !== 0 || trig_tot !== 1) $display("FAIL ovf_trig: got bad=%0d tot=%0d expected 0/1", trig_bad, trig_tot); else passed++;
    endtask

    task automatic test_note_off();
        logic [NK-1:0] keys = '0;
        do_reset();
        keys[60] = 1'b1;
        run_pass(keys, 95, 0, 0, 0, 0);
        checks++; if (bus.voice_gate !== 8'h01 || bus.voice_note[6:0] !== 7'd60) $display("FAIL off_on: got %0h/%0d expected 01/60", bus.voice_gate, bus.voice_note[6:0]); else passed++;
        for (int p = 0; p < 2; p++) begin
            run_pass('0, 95, 0, 0, 0, 0);
            checks++; if (bus.voice_gate !== 8'h00 || bus.voice_note[6:0] !== 7'd60) $display("FAIL off_release%0d: got %0h/%0d expected 00/60", p, bus.voice_gate, bus.voice_note[6:0]); else passed++;
            checks++; if (trig_tot !== 0) $display("FAIL off_trig%0d: got %0d expected 0", p, trig_tot); else passed++;
        end
    endtask

    task automatic test_busy_ignore();
        do_reset();
        run_pass(rand_keys(20), 95, 0, 0, 5, 40);
        checks++; if (done_cnt !== 1 || done_first !== 90) $display("FAIL ign_done: got cnt=%0d at=%0d expected 1/90", done_cnt, done_first); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL ign_busy_after: got %0h expected 0", bus.busy); else passed++;
        checks++; if (bus.voice_gate !== exp_gate() || bus.voice_note !== exp_note()) $display("FAIL ign_voices: got %0h/%0h expected %0h/%0h", bus.voice_gate, bus.voice_note, exp_gate(), exp_note()); else passed++;
    endtask

    task automatic test_back_to_back();
        run_pass(rand_keys(15), 185, 1, 0, 0, 0);
        checks++; if (done_cnt !== 2 || done_first !== 90 || done_second !== 180) $display("FAIL b2b_done: got %0d at %0d,%0d expected 2 at 90,180", done_cnt, done_first, done_second); else passed++;
        checks++; if (trig_bad !== 0) $display("FAIL b2b_trig: got %0d bad cycles expected 0", trig_bad); else passed++;
        checks++; if (bus.drop_cnt !== 8'(m_drop) || bus.voice_gate !== exp_gate()) $display("FAIL b2b_state: got %0d/%0h expected %0d/%0h", bus.drop_cnt, bus.voice_gate, m_drop, exp_gate()); else passed++;
    endtask

    task automatic test_snapshot();
        run_pass(rand_keys(25), 95, 0, 1, 0, 0);
        checks++; if (bus.voice_gate !== exp_gate() || bus.voice_note !== exp_note()) $display("FAIL snap_voices: got %0h/%0h expected %0h/%0h", bus.voice_gate, bus.voice_note, exp_gate(), exp_note()); else passed++;
        checks++; if (trig_bad !== 0 || bus.drop_cnt !== 8'(m_drop)) $display("FAIL snap_trig_drop: got bad=%0d drop=%0d expected 0/%0d", trig_bad, bus.drop_cnt, m_drop); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [NK-1:0] keys = rand_keys(40);
        int dn = 0;
        do_reset();
        bus.keys_in = keys; bus.scan_start = 1'b1;
        for (int n = 1; n <= 32; n++) begin @(posedge clk); #1 bus.scan_start = 1'b0; end
        reset = 1'b1;
        #1;
        checks++; if ({bus.busy, bus.scan_done, bus.voice_gate, bus.voice_trig, bus.voice_note, bus.drop_cnt} !== '0)
            $display("FAIL mid_reset_outputs: got %0h/%0h/%0h/%0h expected all 0", bus.busy, bus.voice_gate, bus.voice_note, bus.drop_cnt); else passed++;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int n = 0; n < 95; n++) begin @(posedge clk); #1 if (bus.scan_done) dn++; end
        checks++; if (dn !== 0 || bus.busy !== 1'b0) $display("FAIL mid_no_done: got %0d pulses busy=%0h expected 0/0", dn, bus.busy); else passed++;
        model_clear();
        run_pass(keys, 95, 0, 0, 0, 0);
        checks++; if (bus.voice_gate !== exp_gate() || bus.voice_note !== exp_note() || trig_bad !== 0) $display("FAIL mid_rescan: got %0h/%0h bad=%0d expected %0h/%0h", bus.voice_gate, bus.voice_note, trig_bad, exp_gate(), exp_note()); else passed++;
    endtask

    task automatic test_random();
        for (int p = 0; p < 10; p++) begin
            run_pass(rand_keys($urandom_range(40, 3)), 95, 0, 0, 0, 0);
            checks++; if (bus.voice_gate !== exp_gate()) $display("FAIL rnd%0d_gate: got %0h expected %0h", p, bus.voice_gate, exp_gate()); else passed++;
            checks++; if (bus.voice_note !== exp_note()) $display("FAIL rnd%0d_note: got %0h expected %0h", p, bus.voice_note, exp_note()); else passed++;
            checks++; if (bus.drop_cnt !== 8'(m_drop)) $display("FAIL rnd%0d_drop: got %0d expected %0d", p, bus.drop_cnt, m_drop); else passed++;
            checks++; if (trig_bad !== 0) $display("FAIL rnd%0d_trig: got %0d bad cycles expected 0", p, trig_bad); else passed++;
            checks++; if (dup_notes() !== 0) $display("FAIL rnd%0d_dup: got %0d duplicates expected 0", p, dup_notes()); else passed++;
        end
    endtask

    task automatic test_drop_sat();
        do_reset();
        for (int p = 0; p < 4; p++) begin
            run_pass('1, 95, 0, 0, 0, 0);
            checks++; if (bus.drop_cnt !== 8'(m_drop)) $display("FAIL sat%0d_drop: got %0d expected %0d", p, bus.drop_cnt, m_drop); else passed++;
        end
        checks++; if (bus.drop_cnt !== 8'd255) $display("FAIL sat_final: got %0d expected 255", bus.drop_cnt); else passed++;
    endtask

    initial begin
        bus.keys_in = '0;
        bus.scan_start = 1'b0;
        test_reset();
        test_two_keys();
        test_overflow();
        test_note_off();
        test_busy_ignore();
        test_back_to_back();
        test_snapshot();
        test_reset_mid();
        test_random();
        test_drop_sat();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
